// File: rtl/piezo_pkg.sv
// piezo_pkg: shared types and constants for the piezo tune sequencer.
//   tune_t   - tune identifiers, also the encoding driven on cur_tune
//   state_t  - sequencer FSM states, exposed on state_dbg
//   PERIOD_* - tone periods in system clocks (50 MHz) for the notes used
//   LEN_*    - number of notes in each tune's table
package piezo_pkg;

  typedef enum logic [1:0] {
    TUNE_NONE    = 2'd0,
    TUNE_STEER   = 2'd1,
    TUNE_FANFARE = 2'd2,
    TUNE_BATT    = 2'd3
  } tune_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [14:0] PERIOD_G6 = 15'd31888;
  localparam logic [14:0] PERIOD_C7 = 15'd23889;
  localparam logic [14:0] PERIOD_E7 = 15'd18961;
  localparam logic [14:0] PERIOD_G7 = 15'd15944;

  localparam int unsigned LEN_STEER   = 1;
  localparam int unsigned LEN_FANFARE = 5;
  localparam int unsigned LEN_BATT    = 3;

  // Wide enough to index the longest table.
  localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/piezo_tune_rom.sv
// piezo_tune_rom: combinational note table for all tunes.
//   tune        in  - tune to look up (TUNE_NONE returns a silent entry)
//   idx         in  - note index within the tune
//   note_dur    out - note length in duration ticks
//   note_period out - tone period in clocks
//   last        out - idx is the final note of the tune
module piezo_tune_rom
  import piezo_pkg::*;
(
  input  tune_t            tune,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       note_dur,
  output logic [14:0]      note_period,
  output logic             last
);

  always_comb begin
    note_dur    = 8'd0;
    note_period = 15'd0;
    last        = 1'b1;
    case (tune)
      TUNE_STEER: begin
        note_dur    = 8'd4;
        note_period = PERIOD_C7;
        last        = 1'b1;
      end
      TUNE_FANFARE: begin
        last = (idx == IDX_W'(LEN_FANFARE - 1));
        case (idx)
          3'd0:    begin note_dur = 8'd8;  note_period = PERIOD_C7; end
          3'd1:    begin note_dur = 8'd8;  note_period = PERIOD_E7; end
          3'd2:    begin note_dur = 8'd8;  note_period = PERIOD_G7; end
          3'd3:    begin note_dur = 8'd4;  note_period = PERIOD_E7; end
          3'd4:    begin note_dur = 8'd16; note_period = PERIOD_G7; end
          default: begin note_dur = 8'd0;  note_period = 15'd0;     end
        endcase
      end
      TUNE_BATT: begin
        last = (idx == IDX_W'(LEN_BATT - 1));
        case (idx)
          3'd0:    begin note_dur = 8'd4;  note_period = PERIOD_G7; end
          3'd1:    begin note_dur = 8'd4;  note_period = PERIOD_C7; end
          3'd2:    begin note_dur = 8'd12; note_period = PERIOD_G6; end
          default: begin note_dur = 8'd0;  note_period = 15'd0;     end
        endcase
      end
      default: begin
        note_dur    = 8'd0;
        note_period = 15'd0;
        last        = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/piezo_tune_seq.sv
// piezo_tune_seq: fixed-priority tune arbiter and note sequencer.
//   clk, rst                     - 50 MHz clock, synchronous active-high reset
//   req_batt/fanfare/steer       - tune request pulses (batt highest priority)
//   note_over                    - duration counter reached note_dur
//   dur_clr, dur_en, note_dur    - duration counter control
//   note_period, piezo_active    - tone generator period / enable
//   busy, cur_tune, done         - tune status
//   state_dbg                    - current FSM state (state_t encoding)
//
// Request protocol: a req_* pulse has no ready; it is always accepted on the
// clock edge where it is high and latched into a sticky pending bit. The
// pending bit is the "valid" seen by the arbiter and drops on the edge its
// tune is granted. A request landing on that same edge re-arms the bit.
module piezo_tune_seq
  import piezo_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_batt,
  input  logic        req_fanfare,
  input  logic        req_steer,
  input  logic        note_over,
  output logic        dur_clr,
  output logic        dur_en,
  output logic [7:0]  note_dur,
  output logic [14:0] note_period,
  output logic        piezo_active,
  output logic        busy,
  output logic [1:0]  cur_tune,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t           state;
  tune_t            tune_q;
  logic [IDX_W-1:0] idx;
  logic             last_q;
  logic [PW-1:0]    presc;
  logic [2:0]       pend;      // {batt, fanfare, steer}

  tune_t            grant;
  logic [2:0]       grant_mask;
  tune_t            rom_tune;
  logic [IDX_W-1:0] rom_idx;
  logic [7:0]       rom_dur;
  logic [14:0]      rom_period;
  logic             rom_last;
  logic [PW-1:0]    presc_nx;
  logic [2:0]       pend_nx;

  assign state_dbg = state;

  always_comb begin
    grant      = TUNE_NONE;
    grant_mask = 3'b000;
    if (pend[2]) begin
      grant      = TUNE_BATT;
      grant_mask = 3'b100;
    end else if (pend[1]) begin
      grant      = TUNE_FANFARE;
      grant_mask = 3'b010;
    end else if (pend[0]) begin
      grant      = TUNE_STEER;
      grant_mask = 3'b001;
    end
    // The ROM is addressed with the note about to be loaded so that LOAD
    // already presents registered note_dur/note_period.
    rom_tune = (state == ST_IDLE) ? grant : tune_q;
    rom_idx  = (state == ST_IDLE) ? '0 : idx + 1'b1;
    presc_nx = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    pend_nx  = ((state == ST_IDLE) ? (pend & ~grant_mask) : pend)
               | {req_batt, req_fanfare, req_steer};
  end

  piezo_tune_rom u_rom (
    .tune        (rom_tune),
    .idx         (rom_idx),
    .note_dur    (rom_dur),
    .note_period (rom_period),
    .last        (rom_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      tune_q       <= TUNE_NONE;
      idx          <= '0;
      last_q       <= 1'b0;
      presc        <= '0;
      pend         <= 3'b000;
      dur_clr      <= 1'b0;
      dur_en       <= 1'b0;
      note_dur     <= 8'd0;
      note_period  <= 15'd0;
      piezo_active <= 1'b0;
      busy         <= 1'b0;
      cur_tune     <= 2'd0;
      done         <= 1'b0;
    end else begin
      pend    <= pend_nx;
      dur_clr <= 1'b0;
      dur_en  <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != TUNE_NONE) begin
            tune_q      <= grant;
            idx         <= '0;
            last_q      <= rom_last;
            note_dur    <= rom_dur;
            note_period <= rom_period;
            dur_clr     <= 1'b1;
            busy        <= 1'b1;
            cur_tune    <= grant;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          presc        <= '0;
          piezo_active <= 1'b1;
          // With a prescaler of one, every PLAY cycle is a tick.
          dur_en       <= (TICK_DIV == 1);
          state        <= ST_PLAY;
        end
        ST_PLAY: begin
          if (note_over) begin
            piezo_active <= 1'b0;
            if (last_q) begin
              done        <= 1'b1;
              note_period <= 15'd0;
              state       <= ST_DONE;
            end else begin
              idx         <= rom_idx;
              last_q      <= rom_last;
              note_dur    <= rom_dur;
              note_period <= rom_period;
              dur_clr     <= 1'b1;
              state       <= ST_LOAD;
            end
          end else begin
            presc  <= presc_nx;
            // Registered tick: asserted in the cycle the prescaler sits at
            // its terminal count.
            dur_en <= (presc_nx == PRESC_LAST);
          end
        end
        ST_DONE: begin
          busy     <= 1'b0;
          cur_tune <= 2'd0;
          note_dur <= 8'd0;
          tune_q   <= TUNE_NONE;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_tune_seq.sv
// tb_piezo_tune_seq: bench for piezo_tune_seq with TICK_DIV=4 and a
// behavioural duration counter. Expected per-cycle outputs are generated
// from the note tables and the request/priority rules into exp_q.
module tb_piezo_tune_seq;
  import piezo_pkg::*;

  localparam int TD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_batt = 1'b0;
  logic req_fanfare = 1'b0;
  logic req_steer = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;
  assign rst_n = ~rst;

  logic        note_over;
  logic        dur_clr;
  logic        dur_en;
  logic [7:0]  note_dur;
  logic [14:0] note_period;
  logic        piezo_active;
  logic        busy;
  logic [1:0]  cur_tune;
  logic        done;
  logic [1:0]  state_dbg;

  // Duration counter the sequencer drives.
  logic [7:0] dcnt;
  always_ff @(posedge clk) begin
    if (!rst_n || dur_clr) dcnt <= 8'd0;
    else if (dur_en)       dcnt <= dcnt + 8'd1;
  end
  assign note_over = (dcnt == note_dur);

  piezo_tune_seq #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_batt     (req_batt),
    .req_fanfare  (req_fanfare),
    .req_steer    (req_steer),
    .note_over    (note_over),
    .dur_clr      (dur_clr),
    .dur_en       (dur_en),
    .note_dur     (note_dur),
    .note_period  (note_period),
    .piezo_active (piezo_active),
    .busy         (busy),
    .cur_tune     (cur_tune),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  a_en_in_play: assert property (@(posedge clk) disable iff (rst)
    dur_en |-> (state_dbg == ST_PLAY)) else $error("dur_en seen outside PLAY");
  a_clr_in_load: assert property (@(posedge clk) disable iff (rst)
    dur_clr |-> (state_dbg == ST_LOAD)) else $error("dur_clr seen outside LOAD");

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        clr;
    logic        en;
    logic [7:0]  dur;
    logic        dur_care;
    logic [14:0] period;
    logic        active;
    logic        busy;
    logic [1:0]  cur;
    logic        done;
  } exp_t;

  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_pend[4];
  bit m_rst_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, expv);
    end
  endtask

  // Note tables: tune id 1 steer, 2 fanfare, 3 batt.
  task automatic note_info(input int t, input int i, output int d, output int p);
    d = 0; p = 0;
    if (t == 1) begin
      d = 4; p = 23889;
    end else if (t == 2) begin
      case (i)
        0: begin d = 8;  p = 23889; end
        1: begin d = 8;  p = 18961; end
        2: begin d = 8;  p = 15944; end
        3: begin d = 4;  p = 18961; end
        default: begin d = 16; p = 15944; end
      endcase
    end else begin
      case (i)
        0: begin d = 4;  p = 15944; end
        1: begin d = 4;  p = 23889; end
        default: begin d = 12; p = 31888; end
      endcase
    end
  endtask

  // Queue the full output trace of one tune, starting with its first LOAD.
  task automatic push_tune(input int t);
    int n, d, p;
    exp_t e;
    n = (t == 3) ? 3 : (t == 2) ? 5 : 1;
    for (int i = 0; i < n; i++) begin
      note_info(t, i, d, p);
      e = '0;
      e.clr = 1'b1; e.dur = d[7:0]; e.dur_care = 1'b1; e.period = p[14:0];
      e.busy = 1'b1; e.cur = t[1:0];
      exp_q.push_back(e);
      for (int j = 0; j <= d * TD; j++) begin
        e = '0;
        e.en = (j < d * TD) && (j % TD == TD - 1);
        e.dur = d[7:0]; e.dur_care = 1'b1; e.period = p[14:0];
        e.active = 1'b1; e.busy = 1'b1; e.cur = t[1:0];
        exp_q.push_back(e);
      end
    end
    e = '0;
    e.done = 1'b1; e.busy = 1'b1; e.cur = t[1:0];
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  // Check this cycle's outputs, then drive this cycle's inputs and advance
  // the reference model to the end of the cycle.
  task automatic step(input logic r, input logic b, input logic f, input logic s);
    exp_t e;
    bit was_idle;
    bit granted;
    @(negedge clk);
    was_idle = (exp_q.size() == 0);
    if (!was_idle) e = exp_q.pop_front();
    else begin
      e = '0;
      e.dur_care = m_rst_prev;
    end
    check("dur_clr", dur_clr, e.clr);
    check("dur_en", dur_en, e.en);
    if (e.dur_care) check("note_dur", note_dur, e.dur);
    check("note_period", note_period, e.period);
    check("piezo_active", piezo_active, e.active);
    check("busy", busy, e.busy);
    check("cur_tune", cur_tune, e.cur);
    check("done", done, e.done);
    check("en_outside_play", dur_en && (state_dbg != ST_PLAY), 0);
    check("clr_outside_load", dur_clr && (state_dbg != ST_LOAD), 0);
    cyc++;
    rst = r; req_batt = b; req_fanfare = f; req_steer = s;
    if (r) begin
      exp_q.delete();
      for (int t = 0; t < 4; t++) m_pend[t] = 1'b0;
    end else begin
      granted = 1'b0;
      if (was_idle) begin
        for (int t = 3; t >= 1; t--) begin
          if (m_pend[t] && !granted) begin
            m_pend[t] = 1'b0;
            granted = 1'b1;
            push_tune(t);
          end
        end
      end
      if (b) m_pend[3] = 1'b1;
      if (f) m_pend[2] = 1'b1;
      if (s) m_pend[1] = 1'b1;
    end
    m_rst_prev = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    // steer chirp alone
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(30);
    // fanfare alone
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(200);
    // batt and steer together
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(150);
    // steer and fanfare requested while fanfare plays
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(480);
    // reset in the middle of fanfare note 2, with a steer pending
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(30);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(19);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    // random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 1999) == 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 149) == 0);
    end
    idle(700);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piezo_tune_seq.md
# piezo_tune_seq

Tune sequencer and arbiter for the piezo sounder. It accepts three tune requests (battery-low, fanfare, steer-enable) and grants them in fixed priority. For the granted tune it walks a fixed note table, driving the duration counter (`clr`/`en`/`note_dur` in, `note_over` out) and the period input of the tone generator. It sits between the system status logic and the piezo datapath and is the only block that sequences the duration counter.

## Interface
- `TICK_DIV`, default 1048576: clocks per duration tick (~21 ms at 50 MHz); benches set 4.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_batt` in 1: battery-low tune request pulse, highest priority.
- `req_fanfare` in 1: fanfare request pulse, middle priority.
- `req_steer` in 1: steer-enable chirp request pulse, lowest priority.
- `note_over` in 1: from the duration counter; high when the count has reached `note_dur`.
- `dur_clr` out 1: synchronous clear to the duration counter.
- `dur_en` out 1: one-cycle duration tick to the duration counter.
- `note_dur` out 8: current note length in ticks.
- `note_period` out 15: tone period in clocks; 0 means silent.
- `piezo_active` out 1: tone generator enable.
- `busy` out 1: a tune is in progress.
- `cur_tune` out 2: 0 none, 1 steer, 2 fanfare, 3 batt.
- `done` out 1: one-cycle pulse when a tune finishes.

## Operation
- Each `req_*` high on a clock edge sets a sticky pending bit. The bit clears on the edge its tune is granted.
- A request for the tune that is currently playing sets pending again, so the tune replays afterwards.
- There is no preemption. A playing tune always finishes.
- States:
  - IDLE: if any pending bit is set, grant the highest-priority one, set note index to 0, go to LOAD.
  - LOAD: drive `dur_clr`=1 for one cycle; present `note_dur` and `note_period` from the table; clear the prescaler; go to PLAY.
  - PLAY: `piezo_active`=1. The prescaler counts 0..TICK_DIV-1, and `dur_en`=1 in the cycle it equals TICK_DIV-1. When `note_over`=1: if this is the last note, go to DONE; otherwise increment the index and go to LOAD.
  - DONE: `done`=1, `note_period`=0, `piezo_active`=0; go to IDLE.
- `note_over` is ignored outside PLAY. Table entries have `note_dur`≥1, so `note_over` is 0 in the first PLAY cycle.
- Note tables (period in clocks, duration in ticks):
  - steer: C7 23889/4.
  - fanfare: C7 23889/8, E7 18961/8, G7 15944/8, E7 18961/4, G7 15944/16.
  - batt: G7 15944/4, C7 23889/4, G6 31888/12.
- `rst`: forces IDLE and clears pending bits, prescaler and index. Every output is 0 on the cycle after `rst` is sampled. This holds mid-tune too: the tone stops immediately.

## Timing
- A request in cycle 0 sets pending at the end of cycle 0. IDLE grants in cycle 1, LOAD is cycle 2, PLAY starts in cycle 3.
- `busy`=1 from LOAD of the first note through DONE inclusive.
- `cur_tune` is valid over the same span and 0 otherwise.
- Per-note timing: 1 LOAD cycle, then PLAY for `note_dur`×TICK_DIV+1 cycles. `note_over` rises in the last PLAY cycle.
- Consecutive notes have no gap cycles beyond LOAD; `piezo_active` drops only during LOAD.
- With two tunes queued, DONE is followed by one IDLE cycle, then LOAD of the next tune.
- Simultaneous requests: batt > fanfare > steer. The losers stay pending.

## Structure
- Package `piezo_pkg` holds:
  - the tune-id enum;
  - the state enum;
  - the note-period constants (G6, C7, E7, G7);
  - the table lengths.
- Sub-module `piezo_tune_rom` is combinational. Inputs: tune id and index. Outputs: `note_dur`, `note_period`, `last`.
- The sequencer holds the FSM, pending bits, prescaler and index.

## Test plan
Bench setup: TICK_DIV=4; drive the real duration counter with `rst_n` = ~`rst`.
- Steer chirp: `req_steer` pulse in cycle 0. Required:
  - `dur_clr` in cycle 2;
  - `note_period`=23889 in cycles 2..19;
  - `dur_en` in cycles 6, 10, 14, 18;
  - `done` in cycle 20;
  - `busy` high in cycles 2..20.
- Fanfare: five LOAD pulses, spaced 34, 34, 34 and 18 cycles apart. Period sequence 23889, 18961, 15944, 18961, 15944. A single `done`.
- Simultaneous `req_batt` and `req_steer` in the same cycle: batt plays first (`cur_tune`=3), then steer (`cur_tune`=1). Two `done` pulses.
- `req_steer` during fanfare: fanfare completes unchanged, then steer plays. `req_fanfare` during fanfare: fanfare replays once.
- `rst` asserted mid-note in fanfare note 2: all outputs 0 on the next cycle; pending cleared. No tune starts afterwards until a new request.
- `dur_en` never asserts outside PLAY, and `dur_clr` never asserts outside LOAD: checked by assertions for the whole run.
